param_reg_file: RTL and testbench

Parametrised, clocked register file for the multi-cycle MIPS datapath. It has two combinational read ports and one synchronous write port with write enable. Features:
- optional hard-wired zero register
- optional write-to-read bypass
- per-register busy scoreboard, so multi-cycle control can stall on registers whose results are still outstanding

Sits between instruction decode (read/reserve) and the write-back stage (write).

---
 rtl/param_reg_file.sv | 108 ++++++++++
 tb/tb_param_reg_file.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - parametrised register file with write bypass and per-register busy scoreboard
module param_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regFile [DEPTH];
  logic [DEPTH-1:0]  busyVec;
  logic [DEPTH-1:0]  busyNext;
  logic [CNT_W-1:0]  busyCount;
  logic              wrValid;
  logic              rsvValid;
  logic              cntInc;
  logic              cntDec;

  // Qualify write/reserve requests: index 0 is inert when it is the hard-wired zero register
  always_comb begin
    wrValid  = wr_en  && !(ZERO_REG && (wr_reg  == '0));
    rsvValid = rsv_en && !(ZERO_REG && (rsv_reg == '0));
  end

  // Next busy vector and population-count delta; a reserve on the written index wins
  // because a new producer has been issued for it
  always_comb begin
    busyNext = busyVec;
    if (wrValid) begin
      busyNext[wr_reg] = 1'b0;
    end
    if (rsvValid) begin
      busyNext[rsv_reg] = 1'b1;
    end
    cntDec = wrValid && busyVec[wr_reg] && !(rsvValid && (rsv_reg == wr_reg));
    cntInc = rsvValid && !busyVec[rsv_reg];
  end

  // Register storage: cleared asynchronously, written on the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile[i] <= '0;
      end
    end else if (wrValid) begin
      regFile[wr_reg] <= wr_data;
    end
  end

  // Busy scoreboard and its running count, kept in step on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyVec   <= '0;
      busyCount <= '0;
    end else begin
      busyVec   <= busyNext;
      busyCount <= busyCount + CNT_W'(cntInc) - CNT_W'(cntDec);
    end
  end

  assign busy_cnt = busyCount;

  // Read port 1: same-cycle write forwarding when enabled, zero register masked last
  always_comb begin
    rd_data1 = regFile[rd_reg1];
    busy1    = busyVec[rd_reg1];
    if (BYPASS && wrValid && (wr_reg == rd_reg1)) begin
      rd_data1 = wr_data;
      busy1    = 1'b0;
    end
    if (ZERO_REG && (rd_reg1 == '0)) begin
      rd_data1 = '0;
      busy1    = 1'b0;
    end
  end

  // Read port 2: same structure as port 1
  always_comb begin
    rd_data2 = regFile[rd_reg2];
    busy2    = busyVec[rd_reg2];
    if (BYPASS && wrValid && (wr_reg == rd_reg2)) begin
      rd_data2 = wr_data;
      busy2    = 1'b0;
    end
    if (ZERO_REG && (rd_reg2 == '0)) begin
      rd_data2 = '0;
      busy2    = 1'b0;
    end
  end

endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - scoreboard testbench for param_reg_file
module tb_param_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic        rsv_en;
  logic [4:0]  rsv_reg;
  logic [31:0] rd_data1, rd_data2;
  logic        busy1, busy2;
  logic [5:0]  busy_cnt;
  logic [31:0] nbData1, nbData2;
  logic        nbBusy1, nbBusy2;
  logic [5:0]  nbCnt;

  // 10 ns clock
  always #5 clk = ~clk;

  param_reg_file dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
  );

  param_reg_file #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dutPlain (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_data1(nbData1), .rd_data2(nbData2),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy1(nbBusy1), .busy2(nbBusy2), .busy_cnt(nbCnt)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        re;
    logic [4:0]  rreg;
  } stim_t;

  typedef struct {
    string       tag;
    logic [71:0] vec;
  } exp_t;

  exp_t        sbq[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] mRegs [32];
  logic [31:0] mBusy;

  function automatic logic [71:0] obsVec();
    return {rd_data1, busy1, rd_data2, busy2, busy_cnt};
  endfunction

  function automatic logic [5:0] popCount();
    logic [5:0] c = '0;
    for (int i = 0; i < 32; i++) c += {5'd0, mBusy[i]};
    return c;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    mBusy = '0;
  endtask

  // Reference behaviour at a rising edge: write clears busy, reserve (applied last) sets it
  task automatic modelEdge();
    if (!rst_n) begin
      modelClear();
    end else begin
      if (wr_en && wr_reg != 5'd0) begin
        mRegs[wr_reg] = wr_data;
        mBusy[wr_reg] = 1'b0;
      end
      if (rsv_en && rsv_reg != 5'd0) mBusy[rsv_reg] = 1'b1;
    end
  endtask

  // Expected combinational outputs for the current inputs and model state
  task automatic pushExp(input string tag);
    exp_t        e;
    logic [31:0] d1, d2;
    logic        b1, b2;
    d1 = mRegs[rd_reg1]; b1 = mBusy[rd_reg1];
    d2 = mRegs[rd_reg2]; b2 = mBusy[rd_reg2];
    if (wr_en && wr_reg != 5'd0 && wr_reg == rd_reg1) begin d1 = wr_data; b1 = 1'b0; end
    if (wr_en && wr_reg != 5'd0 && wr_reg == rd_reg2) begin d2 = wr_data; b2 = 1'b0; end
    if (rd_reg1 == 5'd0) begin d1 = '0; b1 = 1'b0; end
    if (rd_reg2 == 5'd0) begin d2 = '0; b2 = 1'b0; end
    e.tag = tag;
    e.vec = {d1, b1, d2, b2, popCount()};
    sbq.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    wr_en = s.we; wr_reg = s.wreg; wr_data = s.wdata;
    rd_reg1 = s.r1; rd_reg2 = s.r2; rsv_en = s.re; rsv_reg = s.rreg;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    exp_t   e;
    stim_t  s[3];
    s[0] = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 1'b0, 5'd0};
    s[1] = '{1'b0, 5'd0, 32'd0, 5'd31, 5'd5, 1'b0, 5'd0};
    s[2] = '{1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b0, 5'd0};
    modelClear();
    rst_n = 1'b1;
    drive(s[0]);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      #1 pushExp($sformatf("reset_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
    pushExp("reset_release");
    e = sbq.pop_front(); compared++;
    if (obsVec() !== e.vec) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
    end
  endtask

  task automatic test_bypass();
    exp_t  e;
    stim_t s = '{1'b1, 5'd4, 32'hDEADBEEF, 5'd4, 5'd0, 1'b0, 5'd0};
    drive(s);
    #1 pushExp("bypass_pre");
    e = sbq.pop_front(); compared++;
    if (obsVec() !== e.vec) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
    end
    compared++;
    if (nbData1 !== 32'h0) begin
      mismatched++;
      $display("FAIL nobypass_pre: got %h want %h", nbData1, 32'h0);
    end
    tick();
    s.we = 1'b0;
    drive(s);
    #1 pushExp("bypass_post");
    e = sbq.pop_front(); compared++;
    if (obsVec() !== e.vec) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
    end
    compared++;
    if (nbData1 !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL nobypass_post: got %h want %h", nbData1, 32'hDEADBEEF);
    end
  endtask

  task automatic test_zero_reg();
    exp_t  e;
    stim_t s[2];
    s[0] = '{1'b1, 5'd0, 32'h1234, 5'd0, 5'd4, 1'b0, 5'd0};
    s[1] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd4, 1'b1, 5'd0};
    for (int i = 0; i < 2; i++) begin
      drive(s[i]);
      #1 pushExp($sformatf("zero_pre_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
      tick();
      pushExp($sformatf("zero_post_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
    end
    compared++;
    if ({nbData1, nbBusy1, nbCnt} !== {32'h1234, 1'b1, 6'd1}) begin
      mismatched++;
      $display("FAIL plain_reg0: got %h/%b/%0d want 1234/1/1", nbData1, nbBusy1, nbCnt);
    end
  endtask

  task automatic test_reserve();
    exp_t  e;
    stim_t s[4];
    s[0] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 1'b1, 5'd7};
    s[1] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 1'b1, 5'd9};
    s[2] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 1'b1, 5'd9};
    s[3] = '{1'b1, 5'd7, 32'hA5, 5'd7, 5'd9, 1'b0, 5'd0};
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      #1 pushExp($sformatf("rsv_pre_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
      tick();
      pushExp($sformatf("rsv_post_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
    end
    compared++;
    if ({busy_cnt, busy1, busy2} !== {6'd1, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL rsv_final: got cnt=%0d b1=%b b2=%b want cnt=1 b1=0 b2=1", busy_cnt, busy1, busy2);
    end
  endtask

  task automatic test_same_cycle();
    exp_t  e;
    stim_t s[3];
    s[0] = '{1'b1, 5'd9, 32'h55, 5'd9, 5'd3, 1'b0, 5'd0};
    s[1] = '{1'b1, 5'd3, 32'hCAFE0003, 5'd3, 5'd9, 1'b1, 5'd3};
    s[2] = '{1'b1, 5'd3, 32'h77, 5'd3, 5'd10, 1'b1, 5'd10};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      #1 pushExp($sformatf("same_pre_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
      tick();
      if (i == 1) begin
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        compared++;
        if ({rd_data1, busy1, busy_cnt} !== {32'hCAFE0003, 1'b1, 6'd1}) begin
          mismatched++;
          $display("FAIL same_reg3: got %h/%b/%0d want cafe0003/1/1", rd_data1, busy1, busy_cnt);
        end
      end
      pushExp($sformatf("same_post_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    stim_t s;
    for (int i = 0; i < 60; i++) begin
      s.we    = 1'($urandom_range(0, 1));
      s.wreg  = 5'($urandom_range(0, 15));
      s.wdata = $urandom;
      s.r1    = (i % 4 == 0) ? s.wreg : 5'($urandom_range(0, 15));
      s.r2    = 5'($urandom_range(0, 15));
      s.re    = 1'($urandom_range(0, 1));
      s.rreg  = (i % 5 == 0) ? s.wreg : 5'($urandom_range(0, 15));
      drive(s);
      #1 pushExp($sformatf("b2b_pre_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
      tick();
      pushExp($sformatf("b2b_post_%0d", i));
      e = sbq.pop_front(); compared++;
      if (obsVec() !== e.vec) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t  e;
    stim_t s[4];
    s[0] = '{1'b1, 5'd1, 32'h11, 5'd1, 5'd2, 1'b0, 5'd0};
    s[1] = '{1'b1, 5'd2, 32'h22, 5'd1, 5'd2, 1'b1, 5'd2};
    s[2] = '{1'b1, 5'd3, 32'h33, 5'd1, 5'd2, 1'b1, 5'd3};
    s[3] = '{1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      tick();
    end
    drive(s[3]);
    #1 pushExp("arst_before");
    e = sbq.pop_front(); compared++;
    if (obsVec() !== e.vec) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
    end
    @(negedge clk);
    rst_n = 1'b0;
    modelClear();
    #1 pushExp("arst_during");
    e = sbq.pop_front(); compared++;
    if (obsVec() !== e.vec) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
    end
    compared++;
    if ({rd_data1, rd_data2, busy2, busy_cnt} !== 71'd0) begin
      mismatched++;
      $display("FAIL arst_zero: got %h %h %b %0d want all zero", rd_data1, rd_data2, busy2, busy_cnt);
    end
    #2 rst_n = 1'b1;
    tick();
    s[3].r1 = 5'd3;
    drive(s[3]);
    #1 pushExp("arst_after");
    e = sbq.pop_front(); compared++;
    if (obsVec() !== e.vec) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
    end
    // A write and reserve presented while reset is held must not land
    rst_n = 1'b0;
    modelClear();
    drive('{1'b1, 5'd6, 32'h66, 5'd1, 5'd2, 1'b1, 5'd8});
    tick();
    drive('{1'b0, 5'd0, 32'h0, 5'd6, 5'd8, 1'b0, 5'd0});
    rst_n = 1'b1;
    #1 pushExp("arst_noedge");
    e = sbq.pop_front(); compared++;
    if (obsVec() !== e.vec) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", e.tag, obsVec(), e.vec);
    end
    tick();
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_reserve();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
